// File: rtl/cva6_feeder_pkg.sv
// ============================================================================
// Module : cva6_feeder_pkg
// Brief  : Shared opcodes, feeder state encoding and load/store decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cva6_feeder_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_BUBBLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic logic is_mem_op(input logic [31:0] instr);
      return (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cva6_instr_feeder.sv
// ============================================================================
// Module : cva6_instr_feeder
// Brief  : Snapshots a fixed program on start and issues it to the CVA6 shim
//          under valid/ready, with bubbles after loads/stores.
//          Optional macro CVA6_FEEDER_MEMRESP_WAIT_EN: bubble waits on
//          mem_resp_i instead of a fixed STALL_CYCLES count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cva6_instr_feeder
   import cva6_feeder_pkg::*;
#(
   parameter int PROG_LEN     = 4,
   parameter int STALL_CYCLES = 1,
   parameter int PC_W         = $clog2(PROG_LEN + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [PROG_LEN*32-1:0] prog_i,
`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
   input  logic                  mem_resp_i,
`endif
   output logic [31:0]           instr_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [PC_W-1:0]       pc_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int            c_CNT_W   = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
   localparam logic          c_BUB_EN  = (STALL_CYCLES > 0);
   localparam logic [PC_W-1:0] c_PC_LAST = PC_W'(PROG_LEN);

   state_t               r_state, w_state_n;
   logic [31:0]          r_instr, w_instr_n;
   logic                 r_valid, w_valid_n;
   logic [PC_W-1:0]      r_pc,    w_pc_n;
   logic                 r_busy,  w_busy_n;
   logic                 r_done,  w_done_n;
   logic [c_CNT_W-1:0]   r_cnt,   w_cnt_n;
   logic                 w_load;
   logic                 w_fire;
   logic [PC_W-1:0]      w_pc_inc;
   logic [31:0]          w_slot_cur;
   logic [31:0]          w_slot_next;
   logic [31:0]          r_buf [PROG_LEN];

   assign w_fire   = r_valid && instr_ready_i;
   assign w_pc_inc = r_pc + PC_W'(1);

   // Program snapshot; only written on an accepted start.
   generate
      for (genvar k = 0; k < PROG_LEN; k++) begin : g_buf
         always_ff @(posedge clk_i) begin
            if (w_load) begin
               r_buf[k] <= prog_i[32*k +: 32];
            end
         end
      end
   endgenerate

   always_comb begin
      w_slot_cur  = 32'd0;
      w_slot_next = 32'd0;
      for (int k = 0; k < PROG_LEN; k++) begin
         if (r_pc == PC_W'(k)) begin
            w_slot_cur = r_buf[k];
         end
         if (w_pc_inc == PC_W'(k)) begin
            w_slot_next = r_buf[k];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_instr <= 32'd0;
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_instr <= w_instr_n;
         r_valid <= w_valid_n;
         r_pc    <= w_pc_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         r_cnt   <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_instr_n = r_instr;
      w_valid_n = r_valid;
      w_pc_n    = r_pc;
      w_done_n  = r_done;
      w_cnt_n   = r_cnt;
      w_load    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               w_load    = 1'b1;
               w_state_n = ST_ISSUE;
               w_valid_n = 1'b1;
               w_instr_n = prog_i[31:0];
               w_pc_n    = '0;
               w_done_n  = 1'b0;
               w_cnt_n   = '0;
            end
         end
         ST_ISSUE: begin
            if (w_fire) begin
               w_pc_n = w_pc_inc;
               if (w_pc_inc == c_PC_LAST) begin
                  w_state_n = ST_DONE;
                  w_valid_n = 1'b0;
                  w_done_n  = 1'b1;
`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
               end else if (is_mem_op(r_instr)) begin
`else
               end else if (c_BUB_EN && is_mem_op(r_instr)) begin
`endif
                  w_state_n = ST_BUBBLE;
                  w_valid_n = 1'b0;
                  w_cnt_n   = c_CNT_W'(STALL_CYCLES);
               end else begin
                  w_instr_n = w_slot_next;
               end
            end
         end
         ST_BUBBLE: begin
`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
            if (mem_resp_i) begin
`else
            w_cnt_n = r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
`endif
               w_state_n = ST_ISSUE;
               w_valid_n = 1'b1;
               w_instr_n = w_slot_cur;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_valid_n = 1'b0;
         end
      endcase
      w_busy_n = (w_state_n == ST_ISSUE) || (w_state_n == ST_BUBBLE);
   end

   assign instr_o       = r_instr;
   assign instr_valid_o = r_valid;
   assign pc_o          = r_pc;
   assign busy_o        = r_busy;
   assign done_o        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cva6_instr_feeder.sv
// ============================================================================
// Module : tb_cva6_instr_feeder
// Brief  : Self-checking bench for cva6_instr_feeder (table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cva6_instr_feeder;

   localparam int PL = 4;

   localparam logic [31:0] A0 = 32'h00100093;
   localparam logic [31:0] A1 = 32'h00200093;
   localparam logic [31:0] A2 = 32'h00300093;
   localparam logic [31:0] A3 = 32'h00400093;
   localparam logic [31:0] SW = 32'h0020a023;
   localparam logic [31:0] LW = 32'h0000a103;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [PL*32-1:0] prog;
   logic            ready;
   logic            mem_resp;
   logic [31:0]     instr;
   logic            valid;
   logic [2:0]      pc;
   logic            busy;
   logic            done;

   logic            start1;
   logic [31:0]     prog1;
   logic [31:0]     instr1;
   logic            valid1;
   logic [0:0]      pc1;
   logic            busy1;
   logic            done1;

   always #5 clk = ~clk;

   cva6_instr_feeder #(.PROG_LEN(PL), .STALL_CYCLES(1)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .prog_i        (prog),
`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
      .mem_resp_i    (mem_resp),
`endif
      .instr_o       (instr),
      .instr_valid_o (valid),
      .instr_ready_i (ready),
      .pc_o          (pc),
      .busy_o        (busy),
      .done_o        (done)
   );

   cva6_instr_feeder #(.PROG_LEN(1), .STALL_CYCLES(1)) u_dut1 (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start1),
      .prog_i        (prog1),
`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
      .mem_resp_i    (mem_resp),
`endif
      .instr_o       (instr1),
      .instr_valid_o (valid1),
      .instr_ready_i (ready),
      .pc_o          (pc1),
      .busy_o        (busy1),
      .done_o        (done1)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      int          pc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [PL*32-1:0] prog;
      int               cycles;
      int               bubbles;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected issue order on every fire, checks hold while stalled.
   logic        p_stall = 1'b0;
   logic [31:0] p_instr;
   logic [2:0]  p_pc;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_instr", instr, p_instr);
            chk("hold_pc", 32'(pc), 32'(p_pc));
         end
         if (valid && ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_fire", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("fire_instr", instr, e.instr);
               chk("fire_pc", 32'(pc), 32'(e.pc));
            end
         end
         p_stall = valid && !ready;
         p_instr = instr;
         p_pc    = pc;
      end
   end

   task automatic do_start(input logic [PL*32-1:0] p);
      exp_t e;
      start = 1'b1;
      prog  = p;
      for (int k = 0; k < PL; k++) begin
         e.instr = p[32*k +: 32];
         e.pc    = k;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_to_done(output int cyc, output int bub);
      cyc = 0;
      bub = 0;
      while (cyc < 60) begin
         @(negedge clk);
         if (done) break;
         if (!valid) bub++;
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int c, b;
      vecs[0] = '{{A3, A2, A1, A0}, 4, 0};
      vecs[1] = '{{A3, LW, SW, A0}, 6, 2};
      vecs[2] = '{{LW, LW, LW, LW}, 7, 3};
      vecs[3] = '{{A3, SW, A1, SW}, 6, 2};
      vecs[4] = '{{SW, A2, A1, A0}, 4, 0};

      rst = 1'b1; start = 1'b0; prog = '0; ready = 1'b1; mem_resp = 1'b1;
      start1 = 1'b0; prog1 = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instr", instr, 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         do_start(vecs[i].prog);
         run_to_done(c, b);
         chk("vec_cycles", 32'(c), 32'(vecs[i].cycles));
         chk("vec_bubbles", 32'(b), 32'(vecs[i].bubbles));
         chk("vec_done", 32'(done), 32'd1);
         chk("vec_pc", 32'(pc), 32'd4);
         chk("vec_valid", 32'(valid), 32'd0);
         chk("vec_busy", 32'(busy), 32'd0);
         chk("vec_sb_empty", 32'(sb.size()), 32'd0);
      end

      // Ready held low for three cycles on slot 0.
      ready = 1'b0;
      do_start({A3, A2, A1, A0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(valid), 32'd1);
         chk("stall_instr", instr, A0);
         chk("stall_pc", 32'(pc), 32'd0);
         @(posedge clk); #1;
      end
      ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_pc_after", 32'(pc), 32'd1);
      @(posedge clk); #1;
      run_to_done(c, b);
      chk("stall_done_pc", 32'(pc), 32'd4);

      // Start during ISSUE is ignored; start in DONE reloads.
      ready = 1'b0;
      do_start({A0, A1, A2, A3});
      start = 1'b1;
      prog  = {LW, SW, LW, SW};
      @(posedge clk); #1;
      start = 1'b0;
      ready = 1'b1;
      run_to_done(c, b);
      chk("ign_cycles", 32'(c), 32'd4);
      chk("ign_sb_empty", 32'(sb.size()), 32'd0);
      do_start({A2, A3, A0, A1});
      @(negedge clk);
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_pc", 32'(pc), 32'd0);
      chk("restart_valid", 32'(valid), 32'd1);
      @(posedge clk); #1;
      run_to_done(c, b);
      chk("restart_cycles", 32'(c), 32'd3);
      chk("restart_end_pc", 32'(pc), 32'd4);

      // Reset while in BUBBLE, then replay.
      do_start({A3, A2, A1, SW});
      @(posedge clk); #1;
      @(negedge clk);
      chk("bub_valid", 32'(valid), 32'd0);
      chk("bub_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_pc", 32'(pc), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      do_start({A3, A2, A1, SW});
      run_to_done(c, b);
      chk("replay_cycles", 32'(c), 32'd5);
      chk("replay_bubbles", 32'(b), 32'd1);
      chk("replay_sb_empty", 32'(sb.size()), 32'd0);

      // Single-instruction program: one fire reaches DONE.
      start1 = 1'b1;
      prog1  = LW;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("p1_valid", 32'(valid1), 32'd1);
      chk("p1_instr", instr1, LW);
      chk("p1_pc", 32'(pc1), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("p1_done", 32'(done1), 32'd1);
      chk("p1_valid_end", 32'(valid1), 32'd0);
      chk("p1_pc_end", 32'(pc1), 32'd1);
      chk("p1_busy_end", 32'(busy1), 32'd0);
      @(posedge clk); #1;

`ifdef CVA6_FEEDER_MEMRESP_WAIT_EN
      // Bubble held until mem_resp_i is seen.
      mem_resp = 1'b0;
      do_start({A3, A2, A1, LW});
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) mem_resp = 1'b1;
         @(negedge clk);
         chk("resp_wait_valid", 32'(valid), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("resp_issue_valid", 32'(valid), 32'd1);
      chk("resp_issue_instr", instr, A1);
      chk("resp_issue_pc", 32'(pc), 32'd1);
      @(posedge clk); #1;
      run_to_done(c, b);
      chk("resp_sb_empty", 32'(sb.size()), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
